// File: rtl/packer_pkg.sv
// Shared types and constants for the symbol packer: FSM encoding, default widths
// and a constant-safe clog2 helper.
package packer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_WORD_W = 8;

  // Never returns 0, so a counter sized with it always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/packer_reg_salida.sv
// One-entry valid/ready output holding register with sticky overflow on a dropped word.
// Optional parity_out is built when PACKER_SIMBOLOS_PARITY_EN is defined.
module packer_reg_salida #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              load_req,
  input  logic              ready_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
`ifdef PACKER_SIMBOLOS_PARITY_EN
  output logic              parity_out,
`endif
  output logic              overflow
);

  logic can_load;

  // An empty register, or one draining this very cycle, may take a new word.
  assign can_load = !valid_out || ready_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      overflow   <= 1'b0;
`ifdef PACKER_SIMBOLOS_PARITY_EN
      parity_out <= 1'b0;
`endif
    end else if (load_req && can_load) begin
      data_out   <= word_in;
      valid_out  <= 1'b1;
`ifdef PACKER_SIMBOLOS_PARITY_EN
      parity_out <= ^word_in;
`endif
    end else begin
      if (load_req) overflow <= 1'b1;
      if (valid_out && ready_in) valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/packer_simbolos.sv
// Packs the DATA_W-bit symbol stream from the memory mux into WORD_W-bit words.
// Optional parity output: define PACKER_SIMBOLOS_PARITY_EN.
module packer_simbolos
  import packer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int MSB_FIRST = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DATA_W-1:0]                      data_in,
  input  logic                                   valid_in,
  input  logic                                   flush,
  input  logic                                   ready_in,
  output logic [WORD_W-1:0]                      data_out,
  output logic                                   valid_out,
`ifdef PACKER_SIMBOLOS_PARITY_EN
  output logic                                   parity_out,
`endif
  output logic                                   overflow,
  output logic [clog2(WORD_W/DATA_W)-1:0]        sym_count
);

  localparam int N     = WORD_W / DATA_W;
  localparam int CNT_W = clog2(N);

  state_t            state;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] merged;
  logic              last_sym;
  logic              complete;
  int                base;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    merged = acc;
    if (MSB_FIRST != 0) base = WORD_W - DATA_W * (int'(sym_count) + 1);
    else                base = DATA_W * int'(sym_count);
    if (valid_in) merged[base +: DATA_W] = data_in;
    last_sym = valid_in && (sym_count == CNT_W'(N - 1));
    // A same-cycle symbol is merged before a flush closes the word.
    complete = last_sym || (flush && (state == FILL || valid_in));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sym_count <= '0;
      acc       <= '0;
    end else if (complete) begin
      // Clearing acc here is what zero-pads the next flushed word.
      state     <= IDLE;
      sym_count <= '0;
      acc       <= '0;
    end else if (valid_in) begin
      state     <= FILL;
      sym_count <= sym_count + 1'b1;
      acc       <= merged;
    end
  end

  packer_reg_salida #(
    .WORD_W(WORD_W)
  ) u_reg_salida (
    .clk       (clk),
    .reset     (reset),
    .word_in   (merged),
    .load_req  (complete),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .valid_out (valid_out),
`ifdef PACKER_SIMBOLOS_PARITY_EN
    .parity_out(parity_out),
`endif
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_packer_simbolos.sv
// Scoreboard bench for packer_simbolos: one MSB-first and one LSB-first instance
// share stimulus; expected words are queued when driven and popped on output.
module tb_packer_simbolos;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] data_in;
  logic       valid_in;
  logic       flush;
  logic       ready_in;

  logic [7:0] data_out,  data_out_l;
  logic       valid_out, valid_out_l;
  logic       overflow,  overflow_l;
  logic [1:0] sym_count, sym_count_l;
`ifdef PACKER_SIMBOLOS_PARITY_EN
  logic       parity_out, parity_out_l;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0] q_msb[$];
  logic [7:0] q_lsb[$];
  logic [1:0] cur[$];

  always #5 clk = ~clk;

  packer_simbolos #(.DATA_W(2), .WORD_W(8), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_in(ready_in), .data_out(data_out),
    .valid_out(valid_out),
`ifdef PACKER_SIMBOLOS_PARITY_EN
    .parity_out(parity_out),
`endif
    .overflow(overflow), .sym_count(sym_count)
  );

  packer_simbolos #(.DATA_W(2), .WORD_W(8), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .ready_in(ready_in), .data_out(data_out_l),
    .valid_out(valid_out_l),
`ifdef PACKER_SIMBOLOS_PARITY_EN
    .parity_out(parity_out_l),
`endif
    .overflow(overflow_l), .sym_count(sym_count_l)
  );

  // Reference packing built by shifting symbols in, independent of bit indexing.
  function automatic logic [7:0] model(input logic [1:0] s[$], input bit msb);
    logic [7:0] w;
    w = 8'h00;
    if (msb) begin
      foreach (s[i]) w = {w[5:0], s[i]};
      w = w << (2 * (4 - s.size()));
    end else begin
      for (int i = s.size() - 1; i >= 0; i--) w = {w[5:0], s[i]};
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic close_word();
    q_msb.push_back(model(cur, 1'b1));
    q_lsb.push_back(model(cur, 1'b0));
    cur.delete();
  endtask

  task automatic send(input logic [1:0] sym, input bit with_flush = 1'b0);
    valid_in = 1'b1;
    data_in  = sym;
    flush    = with_flush;
    cur.push_back(sym);
    if (cur.size() == 4 || with_flush) close_word();
    step();
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; data_in = 2'b00;
    step();
    reset = 1'b0;
    q_msb.delete(); q_lsb.delete(); cur.delete();
  endtask

  task automatic sb_compare(input string name);
    logic [7:0] em, el;
    total += 2;
    if (q_msb.size() == 0 || q_lsb.size() == 0) begin
      $display("FAIL %s: scoreboard empty while DUT shows %h/%h", name, data_out, data_out_l);
    end else begin
      em = q_msb.pop_front();
      el = q_lsb.pop_front();
      if (data_out !== em || !valid_out)
        $display("FAIL %s msb: got %h valid %b, want %h valid 1", name, data_out, valid_out, em);
      else passed++;
      if (data_out_l !== el || !valid_out_l)
        $display("FAIL %s lsb: got %h valid %b, want %h valid 1", name, data_out_l, valid_out_l, el);
      else passed++;
`ifdef PACKER_SIMBOLOS_PARITY_EN
      total++;
      if (parity_out !== ^em || parity_out_l !== ^el)
        $display("FAIL %s parity: got %b/%b, want %b/%b", name, parity_out, parity_out_l, ^em, ^el);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset();
    ready_in = 1'b0;
    do_reset();
    total++;
    if ({data_out, valid_out, overflow, sym_count, data_out_l, valid_out_l, overflow_l, sym_count_l} !== '0)
      $display("FAIL reset: got %h %b %b %0d / %h %b %b %0d, want all 0", data_out, valid_out,
               overflow, sym_count, data_out_l, valid_out_l, overflow_l, sym_count_l);
    else passed++;
`ifdef PACKER_SIMBOLOS_PARITY_EN
    total++;
    if (parity_out !== 1'b0 || parity_out_l !== 1'b0)
      $display("FAIL reset parity: got %b/%b, want 0/0", parity_out, parity_out_l);
    else passed++;
`endif
  endtask

  task automatic test_basic();
    logic [1:0] syms[4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) send(syms[i]);
    total++;
    if (valid_out !== 1'b0 || sym_count !== 2'd3)
      $display("FAIL basic early: valid %b count %0d, want valid 0 count 3", valid_out, sym_count);
    else passed++;
    send(syms[3]);
    total++;
    if (q_msb[0] !== 8'hC9 || q_lsb[0] !== 8'h63)
      $display("FAIL basic model: got %h/%h, want c9/63", q_msb[0], q_lsb[0]);
    else passed++;
    sb_compare("basic");
    total++;
    if (sym_count !== 2'd0) $display("FAIL basic count: got %0d, want 0", sym_count);
    else passed++;
    step();
    total++;
    if (valid_out !== 1'b0 || valid_out_l !== 1'b0)
      $display("FAIL basic drain: valid %b/%b, want 0/0", valid_out, valid_out_l);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(2'b01);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h55 || overflow !== 1'b0)
      $display("FAIL ovf first: got %h valid %b ovf %b, want 55 1 0", data_out, valid_out, overflow);
    else passed++;
    for (int i = 0; i < 4; i++) send(2'b01);
    void'(q_msb.pop_back());
    void'(q_lsb.pop_back());
    total++;
    if (overflow !== 1'b1 || overflow_l !== 1'b1 || sym_count !== 2'd0)
      $display("FAIL ovf set: got %b/%b count %0d, want 1/1 count 0", overflow, overflow_l, sym_count);
    else passed++;
    sb_compare("ovf held");
    ready_in = 1'b1;
    step();
    total++;
    if (valid_out !== 1'b0 || overflow !== 1'b1)
      $display("FAIL ovf sticky: valid %b ovf %b, want 0 1", valid_out, overflow);
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    ready_in = 1'b1;
    send(2'b10);
    send(2'b11);
    flush = 1'b1;
    close_word();
    step();
    flush = 1'b0;
    total++;
    if (q_msb[0] !== 8'hB0 || sym_count !== 2'd0)
      $display("FAIL flush: model %h count %0d, want b0 count 0", q_msb[0], sym_count);
    else passed++;
    sb_compare("flush");
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    total++;
    if (valid_out !== 1'b0 || valid_out_l !== 1'b0 || sym_count !== 2'd0)
      $display("FAIL flush idle: valid %b/%b count %0d, want 0/0 0", valid_out, valid_out_l, sym_count);
    else passed++;
    // Flush together with the second symbol keeps that symbol.
    send(2'b01);
    send(2'b10, 1'b1);
    sb_compare("flush+valid");
    total++;
    if (data_out !== 8'h60 || data_out_l !== 8'h09)
      $display("FAIL flush+valid: got %h/%h, want 60/09", data_out, data_out_l);
    else passed++;
    step();
    for (int i = 0; i < 3; i++) send(2'b10);
    send(2'b01, 1'b1);
    sb_compare("flush+last");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) send(2'b11);
    do_reset();
    total++;
    if (sym_count !== 2'd0 || valid_out !== 1'b0)
      $display("FAIL reset mid: count %0d valid %b, want 0 0", sym_count, valid_out);
    else passed++;
    send(2'b00); send(2'b00); send(2'b00); send(2'b11);
    sb_compare("reset mid");
    total++;
    if (data_out !== 8'h03 || data_out_l !== 8'hC0)
      $display("FAIL reset mid word: got %h/%h, want 03/c0", data_out, data_out_l);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] a[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] b[4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) send(a[i]);
    for (int i = 0; i < 3; i++) send(b[i]);
    sb_compare("b2b first");
    ready_in = 1'b1;
    send(b[3]);
    total++;
    if (valid_out !== 1'b1 || overflow !== 1'b0 || overflow_l !== 1'b0)
      $display("FAIL b2b: valid %b ovf %b/%b, want 1 0/0", valid_out, overflow, overflow_l);
    else passed++;
    sb_compare("b2b second");
    step();
    total++;
    if (valid_out !== 1'b0) $display("FAIL b2b drain: valid %b, want 0", valid_out);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; data_in = 2'b00; ready_in = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (q_msb.size() != 0 || q_lsb.size() != 0)
      $display("FAIL scoreboard leftover: %0d/%0d words, want 0", q_msb.size(), q_lsb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
